// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, with a valid/ready result handshake and flush.
//
// state  | meaning
// S_IDLE | ready for a new operation
// S_CALC | iterating, cnt_q counts 0..DATA_WIDTH-1
// S_DONE | result_q valid, waiting for out_ready
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         result_q, result_d;

  logic           sgn1, sgn2, s1, s2, is_div, div0, ovf;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     mul_sum, rem_sh, diff;
  logic [2*W-1:0] mul_nx, div_nx, iter_nx, prod_s;
  logic [W-1:0]   quot_s, rem_s, fin;

  always_comb begin
    sgn1   = !((op == 3'b011) || (op == 3'b101) || (op == 3'b111));
    sgn2   = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    s1     = sgn1 & data1[W-1];
    s2     = sgn2 & data2[W-1];
    mag1   = s1 ? -data1 : data1;
    mag2   = s2 ? -data2 : data2;
    is_div = op[2];
    div0   = (data2 == '0);
    ovf    = ((op == 3'b100) || (op == 3'b110)) &&
             (data1 == {1'b1, {(W-1){1'b0}}}) && (data2 == '1);

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
    mul_nx  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    // Divide: {remainder, dividend/quotient} shift left together.
    rem_sh  = acc_q[2*W-1:W-1];
    diff    = rem_sh - {1'b0, opb_q};
    div_nx  = diff[W] ? {acc_q[2*W-2:0], 1'b0} : {diff[W-1:0], acc_q[W-2:0], 1'b1};
    iter_nx = op_q[2] ? div_nx : mul_nx;

    prod_s = neg_q  ? -iter_nx : iter_nx;
    quot_s = neg_q  ? -iter_nx[W-1:0] : iter_nx[W-1:0];
    rem_s  = rneg_q ? -iter_nx[2*W-1:W] : iter_nx[2*W-1:W];
    case (op_q)
      3'b000:                 fin = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*W-1:W];
      3'b100, 3'b101:         fin = quot_s;
      default:                fin = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = op;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          cnt_d  = '0;
          if (is_div && div0) begin
            result_d = op[1] ? data1 : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op[1] ? '0 : data1;
            state_d  = S_DONE;
          end else begin
            acc_d   = is_div ? {{W{1'b0}}, mag1} : {{W{1'b0}}, mag2};
            opb_d   = is_div ? mag2 : mag1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = iter_nx;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(W - 1)) begin
          result_d = fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule
